// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the push-button event controller.
// Holds the per-button state encoding, event type codes and width helpers.
// Pure declarations: no latency, no backpressure.
package btn_event_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } btn_state_t;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    // Clock cycles per 1 ms tick.
    function automatic int tick_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// One button: debounce FSM, hold counter, long-press and optional auto-repeat.
// Latency: state and event pulses are registered, visible the cycle after the deciding tick.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
// Ports: clk27/reset_n (sync, active-low), tick (1 ms strobe), pin_pressed (1 = pressed),
//        level (debounced state), press_ev/rel_ev/long_ev/rpt_ev (1-cycle event pulses).
// Optional feature: BTN_REPEAT_EN builds the auto-repeat counter; otherwise rpt_ev is tied 0.
module btn_event_fsm
    import btn_event_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 10,
    parameter int LONGPRESS_MS    = 1000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_MS       = 100
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic tick,
    input  logic pin_pressed,
    output logic level,
    output logic press_ev,
    output logic rel_ev,
    output logic long_ev,
    output logic rpt_ev
);

    localparam int DEB_W  = cnt_w(DEBOUNCE_MS);
    localparam int HOLD_W = cnt_w(LONGPRESS_MS);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_MS);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONGPRESS_MS);

    btn_state_t        state;
    logic [DEB_W-1:0]  stab;
    logic [DEB_W-1:0]  stab_inc;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_inc;
    logic              deb_done;

    // A new debounce run starts at 1 from a settled state and extends inside DEB_*.
    // With DEBOUNCE_MS == 1 the first sample already completes the run.
    assign stab_inc = (state == IDLE || state == PRESSED) ? DEB_W'(1) : stab + DEB_W'(1);
    assign deb_done = (stab_inc == DEB_MAX);
    assign hold_inc = hold + HOLD_W'(1);

`ifdef BTN_REPEAT_EN
    // Counts held ticks; on reaching the delay it fires and rewinds by REPEAT_MS so the
    // next pulse lands REPEAT_MS later. Needs 1 <= REPEAT_MS <= REPEAT_DELAY_MS.
    localparam int RPT_W = cnt_w(REPEAT_DELAY_MS);
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_inc;
    assign rpt_inc = rpt_cnt + RPT_W'(1);
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY_MS, REPEAT_MS};
    assign rpt_ev = 1'b0;
`endif

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            state    <= IDLE;
            stab     <= '0;
            hold     <= '0;
            level    <= 1'b0;
            press_ev <= 1'b0;
            rel_ev   <= 1'b0;
            long_ev  <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_cnt  <= '0;
            rpt_ev   <= 1'b0;
`endif
        end else begin
            press_ev <= 1'b0;
            rel_ev   <= 1'b0;
            long_ev  <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_ev   <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    IDLE, DEB_PRESS: begin
                        if (!pin_pressed) begin
                            state <= IDLE;
                            stab  <= '0;
                        end else if (deb_done) begin
                            state    <= PRESSED;
                            stab     <= '0;
                            hold     <= '0;
                            level    <= 1'b1;
                            press_ev <= 1'b1;
`ifdef BTN_REPEAT_EN
                            rpt_cnt  <= '0;
`endif
                        end else begin
                            state <= DEB_PRESS;
                            stab  <= stab_inc;
                        end
                    end
                    default: begin  // PRESSED, DEB_REL
                        if (!pin_pressed) begin
                            if (deb_done) begin
                                state  <= IDLE;
                                stab   <= '0;
                                level  <= 1'b0;
                                rel_ev <= 1'b1;
                            end else begin
                                state <= DEB_REL;
                                stab  <= stab_inc;
                            end
                        end else if (state == DEB_REL) begin
                            // Release glitch: resume holding without counting this tick.
                            state <= PRESSED;
                            stab  <= '0;
                        end else begin
                            if (hold != HOLD_MAX) begin
                                hold    <= hold_inc;
                                long_ev <= (hold_inc == HOLD_MAX);
                            end
`ifdef BTN_REPEAT_EN
                            if (rpt_inc == RPT_W'(REPEAT_DELAY_MS)) begin
                                rpt_ev  <= 1'b1;
                                rpt_cnt <= RPT_W'(REPEAT_DELAY_MS - REPEAT_MS);
                            end else begin
                                rpt_cnt <= rpt_inc;
                            end
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounced push-button event controller feeding the Nios status word.
// Latency: pulses one cycle after the deciding 1 ms tick; event_code/event_cnt one cycle after the pulses.
// Backpressure: none; code and counter are latched for polling.
// Ports: clk27, reset_n (sync, active-low), btn_i (active-low pins), btn_state_o, press_o,
//        release_o, long_o, repeat_o, event_code_o ({type, index}), event_cnt_o (wrapping).
// Optional feature: define BTN_REPEAT_EN to build auto-repeat; otherwise repeat_o is 0.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int CLK_FREQ        = 27000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int LONGPRESS_MS    = 1000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_MS       = 100
) (
    input  logic               clk27,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_state_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_o,
    output logic [NUM_BTN-1:0] repeat_o,
    output logic [7:0]         event_code_o,
    output logic [7:0]         event_cnt_o
);

    localparam int DIV   = tick_div(CLK_FREQ);
    localparam int PRE_W = cnt_w(DIV);
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] presc;
    logic             tick;
    logic             any_evt;
    logic [7:0]       code_nxt;

    assign tick = (presc == PRE_TC);

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_event_fsm #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .LONGPRESS_MS   (LONGPRESS_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_MS      (REPEAT_MS)
        ) u_fsm (
            .clk27      (clk27),
            .reset_n    (reset_n),
            .tick       (tick),
            .pin_pressed(~btn_i[i]),
            .level      (btn_state_o[i]),
            .press_ev   (press_o[i]),
            .rel_ev     (release_o[i]),
            .long_ev    (long_o[i]),
            .rpt_ev     (repeat_o[i])
        );
    end

    // Walk from the top index down so the lowest-index button with an event wins.
    always_comb begin
        any_evt  = |{press_o, release_o, long_o, repeat_o};
        code_nxt = event_code_o;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (long_o[i])         code_nxt = {EVT_LONG,    6'(i)};
            else if (repeat_o[i])  code_nxt = {EVT_REPEAT,  6'(i)};
            else if (release_o[i]) code_nxt = {EVT_RELEASE, 6'(i)};
            else if (press_o[i])   code_nxt = {EVT_PRESS,   6'(i)};
        end
    end

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            event_code_o <= '0;
            event_cnt_o  <= '0;
        end else if (any_evt) begin
            event_code_o <= code_nxt;
            event_cnt_o  <= event_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus random button activity,
// every cycle compared against a tick-level reference model of the debouncer.
// Works with or without BTN_REPEAT_EN defined.
module tb_btn_event_ctrl;

    localparam int NB   = 2;
    localparam int FREQ = 4000;
    localparam int DIV  = FREQ / 1000;
    localparam int DEB  = 3;
    localparam int LONG = 10;
    localparam int RD   = 5;
    localparam int RM   = 2;
`ifdef BTN_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic          clk27   = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] btn_i   = '1;
    logic [NB-1:0] btn_state_o, press_o, release_o, long_o, repeat_o;
    logic [7:0]    event_code_o, event_cnt_o;

    btn_event_ctrl #(
        .NUM_BTN(NB), .CLK_FREQ(FREQ), .DEBOUNCE_MS(DEB), .LONGPRESS_MS(LONG),
        .REPEAT_DELAY_MS(RD), .REPEAT_MS(RM)
    ) dut (
        .clk27(clk27), .reset_n(reset_n), .btn_i(btn_i), .btn_state_o(btn_state_o),
        .press_o(press_o), .release_o(release_o), .long_o(long_o), .repeat_o(repeat_o),
        .event_code_o(event_code_o), .event_cnt_o(event_cnt_o)
    );

    always #5 clk27 = ~clk27;

    int vecs = 0;
    int errs = 0;

    // Reference model: per button the accepted level, the run of consecutive ticks that
    // disagree with it, and the number of held ticks since the press was accepted.
    int            ph;
    logic [NB-1:0] m_lvl, m_press, m_rel, m_long, m_rpt;
    int            m_diff [NB];
    int            m_h    [NB];
    logic [7:0]    m_code, m_cnt;

    task automatic clk_step();
        logic [NB-1:0] np, nr, nl, nq;
        logic p;
        @(posedge clk27);
        if (!reset_n) begin
            ph = 0; m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
            m_code = '0; m_cnt = '0;
            for (int b = 0; b < NB; b++) begin m_diff[b] = 0; m_h[b] = 0; end
        end else begin
            if (|{m_press, m_rel, m_long, m_rpt}) begin
                m_cnt = m_cnt + 8'd1;
                for (int b = NB - 1; b >= 0; b--) begin
                    if (m_long[b])       m_code = {2'd2, 6'(b)};
                    else if (m_rpt[b])   m_code = {2'd3, 6'(b)};
                    else if (m_rel[b])   m_code = {2'd1, 6'(b)};
                    else if (m_press[b]) m_code = {2'd0, 6'(b)};
                end
            end
            np = '0; nr = '0; nl = '0; nq = '0;
            if (ph == DIV - 1) begin
                for (int b = 0; b < NB; b++) begin
                    p = ~btn_i[b];
                    if (p != m_lvl[b]) begin
                        m_diff[b]++;
                        if (m_diff[b] == DEB) begin
                            m_lvl[b] = p; m_diff[b] = 0;
                            if (p) begin np[b] = 1'b1; m_h[b] = 0; end
                            else nr[b] = 1'b1;
                        end
                    end else begin
                        if (p && m_diff[b] == 0) begin
                            m_h[b]++;
                            if (m_h[b] == LONG) nl[b] = 1'b1;
                            if (RPT_EN && m_h[b] >= RD && (m_h[b] - RD) % RM == 0) nq[b] = 1'b1;
                        end
                        m_diff[b] = 0;
                    end
                end
            end
            ph = (ph + 1) % DIV;
            m_press = np; m_rel = nr; m_long = nl; m_rpt = nq;
        end
        #1;
    endtask

    function automatic logic [25:0] dut_vec();
        return {btn_state_o, press_o, release_o, long_o, repeat_o, event_code_o, event_cnt_o};
    endfunction

    function automatic logic [25:0] mdl_vec();
        return {m_lvl, m_press, m_rel, m_long, m_rpt, m_code, m_cnt};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; btn_i = '1;
        repeat (3) begin
            clk_step(); vecs++;
            if (dut_vec() !== 26'd0) begin errs++; $display("FAIL reset dut=%h exp=%h", dut_vec(), 26'd0); end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_press_release();
        bit seen = 0;
        btn_i = 2'b10;
        for (int c = 0; c < 6 * DIV; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL press_release dut=%h exp=%h", dut_vec(), mdl_vec()); end
            if (press_o[0]) seen = 1;
        end
        btn_i = 2'b11;
        for (int c = 0; c < 6 * DIV + 2; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL press_release dut=%h exp=%h", dut_vec(), mdl_vec()); end
        end
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL press_seen got=%0b exp=1", seen); end
        vecs++; if (event_code_o !== 8'h40) begin errs++; $display("FAIL release_code got=%h exp=40", event_code_o); end
        vecs++; if (event_cnt_o !== 8'd2) begin errs++; $display("FAIL release_cnt got=%0d exp=2", event_cnt_o); end
    endtask

    task automatic test_bounce();
        logic [7:0] c0 = m_cnt;
        int pulses = 0;
        for (int t = 0; t < 6; t++) begin
            btn_i[0] = t[0];
            for (int c = 0; c < 2 * DIV; c++) begin
                clk_step(); vecs++;
                if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL bounce dut=%h exp=%h", dut_vec(), mdl_vec()); end
                if (|{press_o, release_o, long_o, repeat_o}) pulses++;
            end
        end
        btn_i[0] = 1'b1;
        vecs++; if (pulses !== 0) begin errs++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
        vecs++; if (event_cnt_o !== c0) begin errs++; $display("FAIL bounce_cnt got=%0d exp=%0d", event_cnt_o, c0); end
        vecs++; if (btn_state_o !== 2'b00) begin errs++; $display("FAIL bounce_state got=%b exp=00", btn_state_o); end
    endtask

    task automatic test_long();
        bit got = 0; bit chk = 0; int nlong = 0;
        btn_i[1] = 1'b0;
        for (int c = 0; c < 20 * DIV && !got; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL long dut=%h exp=%h", dut_vec(), mdl_vec()); end
            got = press_o[1];
        end
        vecs++; if (got !== 1'b1) begin errs++; $display("FAIL long_press_wait got=%0b exp=1", got); end
        for (int c = 0; c < 14 * DIV; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL long dut=%h exp=%h", dut_vec(), mdl_vec()); end
            if (chk) begin
                vecs++;
                if (event_code_o !== 8'h81) begin errs++; $display("FAIL long_code got=%h exp=81", event_code_o); end
            end
            chk = long_o[1];
            if (long_o[1]) nlong++;
        end
        vecs++; if (nlong !== 1) begin errs++; $display("FAIL long_count got=%0d exp=1", nlong); end
        btn_i[1] = 1'b1;
        for (int c = 0; c < 6 * DIV + 2; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL long dut=%h exp=%h", dut_vec(), mdl_vec()); end
        end
        vecs++; if (event_code_o !== 8'h41) begin errs++; $display("FAIL long_release_code got=%h exp=41", event_code_o); end
    endtask

    task automatic test_repeat();
        bit got = 0; int nrpt = 0;
        btn_i[0] = 1'b0;
        for (int c = 0; c < 20 * DIV && !got; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL repeat dut=%h exp=%h", dut_vec(), mdl_vec()); end
            got = press_o[0];
        end
        vecs++; if (got !== 1'b1) begin errs++; $display("FAIL repeat_press_wait got=%0b exp=1", got); end
        for (int c = 0; c < 10 * DIV; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL repeat dut=%h exp=%h", dut_vec(), mdl_vec()); end
            if (repeat_o[0]) nrpt++;
        end
        vecs++;
        if (nrpt !== (RPT_EN ? 3 : 0)) begin errs++; $display("FAIL repeat_count got=%0d exp=%0d", nrpt, RPT_EN ? 3 : 0); end
        btn_i[0] = 1'b1;
        for (int c = 0; c < 6 * DIV + 2; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL repeat dut=%h exp=%h", dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] c0 = m_cnt;
        bit got = 0;
        btn_i = 2'b00;
        for (int c = 0; c < 20 * DIV && !got; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL simul dut=%h exp=%h", dut_vec(), mdl_vec()); end
            got = (press_o == 2'b11);
        end
        vecs++; if (got !== 1'b1) begin errs++; $display("FAIL simul_press_wait got=%0b exp=1", got); end
        clk_step();
        vecs++; if (event_code_o !== 8'h00) begin errs++; $display("FAIL simul_code got=%h exp=00", event_code_o); end
        vecs++; if (event_cnt_o !== c0 + 8'd1) begin errs++; $display("FAIL simul_cnt got=%0d exp=%0d", event_cnt_o, c0 + 8'd1); end
        btn_i = 2'b11;
        for (int c = 0; c < 6 * DIV + 2; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL simul dut=%h exp=%h", dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        bit got = 0; int steps = 0;
        btn_i[0] = 1'b0;
        for (int c = 0; c < 20 * DIV && !got; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL rstmid dut=%h exp=%h", dut_vec(), mdl_vec()); end
            got = press_o[0];
        end
        vecs++; if (got !== 1'b1) begin errs++; $display("FAIL rstmid_press_wait got=%0b exp=1", got); end
        repeat (3 * DIV) clk_step();
        reset_n = 1'b0;
        repeat (2) begin
            clk_step(); vecs++;
            if (dut_vec() !== 26'd0) begin errs++; $display("FAIL rstmid_zero dut=%h exp=%h", dut_vec(), 26'd0); end
        end
        reset_n = 1'b1;
        got = 0;
        for (int c = 0; c < 20 * DIV && !got; c++) begin
            clk_step(); vecs++; steps++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL rstmid dut=%h exp=%h", dut_vec(), mdl_vec()); end
            got = press_o[0];
        end
        vecs++; if (steps !== 3 * DIV) begin errs++; $display("FAIL rstmid_latency got=%0d exp=%0d", steps, 3 * DIV); end
        clk_step();
        vecs++; if (event_cnt_o !== 8'd1) begin errs++; $display("FAIL rstmid_cnt got=%0d exp=1", event_cnt_o); end
        btn_i[0] = 1'b1;
        for (int c = 0; c < 6 * DIV + 2; c++) begin
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL rstmid dut=%h exp=%h", dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_random();
        int run [NB];
        for (int b = 0; b < NB; b++) run[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (run[b] == 0) begin
                    btn_i[b] = ~btn_i[b];
                    run[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * DIV)
                                                         : $urandom_range(1, 16 * DIV);
                end else begin
                    run[b]--;
                end
            end
            reset_n = ($urandom_range(0, 799) != 0);
            clk_step(); vecs++;
            if (dut_vec() !== mdl_vec()) begin errs++; $display("FAIL random dut=%h exp=%h", dut_vec(), mdl_vec()); end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_long();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
